// File: rtl/access_scheduler_pkg.sv
// Shared defaults for the beam-timed access scheduler and the rotating
// first-requester search used by its round-robin picker.
package access_scheduler_pkg;

    localparam int DEF_POS_W      = 10;
    localparam int DEF_TICK_LINE  = 480;
    localparam int DEF_TICK_COL   = 0;
    localparam int DEF_SLOT_TICKS = 144;

    // Returns {found, index}: first set bit of req searching owner+1 upward
    // with wrap at n, owner itself last. Without a requester returns {0, owner}.
    function automatic logic [4:0] rr_first(input logic [15:0] req,
                                            input logic [3:0]  owner,
                                            input int          n);
        logic [4:0] res;
        logic [4:0] idx;
        res = {1'b0, owner};
        // Walk from the farthest candidate back so the nearest one wins.
        for (int k = 16; k >= 1; k--) begin
            idx = {1'b0, owner} + 5'(k);
            if (idx >= 5'(n)) idx = idx - 5'(n);
            if (k <= n && req[idx[3:0]]) res = {1'b1, idx[3:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/access_scheduler_rr_pick.sv
// Combinational round-robin search: next requester after the current owner.
module rr_pick
    import access_scheduler_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int IDW         = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IDW-1:0]         owner,
    output logic [IDW-1:0]         nxt,
    output logic                   any_req
);

    logic [4:0] res;

    always_comb begin
        res     = rr_first(16'(req), 4'(owner), NUM_CLIENTS);
        nxt     = IDW'(res[3:0]);
        any_req = res[4];
    end

endmodule

// File: rtl/access_scheduler.sv
// Time-multiplexes a bus between NUM_CLIENTS clients in slots measured in
// beam-position ticks; fixed rotation or request-driven with early release.
module access_scheduler
    import access_scheduler_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int POS_W       = DEF_POS_W,
    parameter int TICK_LINE   = DEF_TICK_LINE,
    parameter int TICK_COL    = DEF_TICK_COL,
    parameter int SLOT_TICKS  = DEF_SLOT_TICKS,
    localparam int IDW        = $clog2(NUM_CLIENTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [POS_W-1:0]       shpos,
    input  logic [POS_W-1:0]       svpos,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic                   skip_idle,
    output logic [NUM_CLIENTS-1:0] ce,
    output logic [IDW-1:0]         grant_id,
    output logic                   slot_start
);

    localparam logic [7:0]     LAST_CNT = 8'(SLOT_TICKS - 1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_CLIENTS - 1);

    logic                   match_d, match_q;
    logic [7:0]             cnt_d, cnt_q;
    logic [IDW-1:0]         owner_d, owner_q;
    logic [NUM_CLIENTS-1:0] ce_d, ce_q;
    logic                   slot_start_d, slot_start_q;
    logic                   tick, slot_end;
    logic [IDW-1:0]         pick_id;
    logic                   pick_any;

    rr_pick #(.NUM_CLIENTS(NUM_CLIENTS)) u_pick (
        .req     (req),
        .owner   (owner_q),
        .nxt     (pick_id),
        .any_req (pick_any)
    );

    assign match_d  = (svpos == POS_W'(TICK_LINE)) && (shpos == POS_W'(TICK_COL));
    assign tick     = match_d && !match_q;
    assign slot_end = (cnt_q == LAST_CNT);

    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (tick) begin
            if (!skip_idle) begin
                if (slot_end) begin
                    owner_d = (owner_q == LAST_ID) ? '0 : owner_q + IDW'(1);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end else if ((slot_end || !req[owner_q]) && pick_any) begin
                // Re-granting the same owner still opens a fresh slot.
                owner_d = pick_id;
                cnt_d   = '0;
            end else if (!slot_end) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
        ce_d          = '0;
        ce_d[owner_d] = 1'b1;
        slot_start_d  = (owner_d != owner_q);
    end

    // ce resets to client 0 rather than zero so the bus never goes unowned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q      <= 1'b0;
            cnt_q        <= '0;
            owner_q      <= '0;
            ce_q         <= NUM_CLIENTS'(1);
            slot_start_q <= 1'b0;
        end else begin
            match_q      <= match_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            ce_q         <= ce_d;
            slot_start_q <= slot_start_d;
        end
    end

    assign ce         = ce_q;
    assign grant_id   = owner_q;
    assign slot_start = slot_start_q;

endmodule

// File: tb/tb_access_scheduler.sv
// Randomized bench for access_scheduler: a 4-client and a 3-client instance
// (SLOT_TICKS=3) run side by side against a slot/owner reference model.
module tb_access_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] shpos = '0, svpos = '0;
    logic [3:0] req = '0;
    logic       skip_idle = 1'b0;
    logic [3:0] ce4;
    logic [1:0] gid4;
    logic       ss4;
    logic [2:0] ce3;
    logic [1:0] gid3;
    logic       ss3;

    int checks = 0;
    int errors = 0;
    int ss_cnt = 0;
    int mown[2], mcnt[2];
    bit mss[2];
    bit mprev = 0;
    int ncl[2] = '{4, 3};
    bit seen_bad3 = 0;

    always #5 clk = ~clk;

    access_scheduler #(.NUM_CLIENTS(4), .POS_W(10), .TICK_LINE(480), .TICK_COL(0), .SLOT_TICKS(3)) dut (
        .clk(clk), .rst_n(rst_n), .shpos(shpos), .svpos(svpos), .req(req),
        .skip_idle(skip_idle), .ce(ce4), .grant_id(gid4), .slot_start(ss4));

    access_scheduler #(.NUM_CLIENTS(3), .POS_W(10), .TICK_LINE(480), .TICK_COL(0), .SLOT_TICKS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .shpos(shpos), .svpos(svpos), .req(req[2:0]),
        .skip_idle(skip_idle), .ce(ce3), .grant_id(gid3), .slot_start(ss3));

    task automatic model_reset();
        mprev = 0;
        for (int d = 0; d < 2; d++) begin
            mown[d] = 0; mcnt[d] = 0; mss[d] = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        if (gid4 !== 2'(mown[0])) begin
            errors++; $display("FAIL %s grant4 got %0d want %0d", tag, gid4, mown[0]);
        end
        checks++;
        if (ce4 !== 4'(1 << mown[0])) begin
            errors++; $display("FAIL %s ce4 got %b want %b", tag, ce4, 4'(1 << mown[0]));
        end
        checks++;
        if (ss4 !== mss[0]) begin
            errors++; $display("FAIL %s slot_start4 got %b want %b", tag, ss4, mss[0]);
        end
        checks++;
        if (gid3 !== 2'(mown[1])) begin
            errors++; $display("FAIL %s grant3 got %0d want %0d", tag, gid3, mown[1]);
        end
        checks++;
        if (ce3 !== 3'(1 << mown[1])) begin
            errors++; $display("FAIL %s ce3 got %b want %b", tag, ce3, 3'(1 << mown[1]));
        end
        checks++;
        if (ss3 !== mss[1]) begin
            errors++; $display("FAIL %s slot_start3 got %b want %b", tag, ss3, mss[1]);
        end
        if (gid3 == 2'd3) seen_bad3 = 1;
        if (ss4 === 1'b1) ss_cnt++;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it.
    task automatic cycle(input bit m, input logic [3:0] r, input bit mode);
        bit tick, done, slot_end;
        int old, c;
        if (m) begin
            svpos = 10'd480; shpos = 10'd0;
        end else begin
            svpos = ($urandom_range(0, 1) != 0) ? 10'd480 : 10'($urandom_range(0, 479));
            shpos = 10'($urandom_range(1, 799));
        end
        req = r;
        skip_idle = mode;
        @(posedge clk);
        if (rst_n) begin
            tick = m && !mprev;
            mprev = m;
            for (int d = 0; d < 2; d++) begin
                old = mown[d];
                if (tick) begin
                    slot_end = (mcnt[d] == 2);
                    if (!mode) begin
                        if (slot_end) begin
                            mown[d] = (mown[d] + 1) % ncl[d]; mcnt[d] = 0;
                        end else mcnt[d]++;
                    end else if (slot_end || !r[mown[d]]) begin
                        done = 0;
                        for (int j = 1; j <= ncl[d]; j++) begin
                            c = (old + j) % ncl[d];
                            if (!done && r[c]) begin
                                mown[d] = c; mcnt[d] = 0; done = 1;
                            end
                        end
                        if (!done && !slot_end) mcnt[d]++;
                    end else mcnt[d]++;
                end
                mss[d] = (mown[d] != old);
            end
        end else model_reset();
        #1;
        check_outputs("cycle");
    endtask

    task automatic tick_frame(input bit mode, input logic [3:0] r);
        cycle(1, r, mode);
        repeat ($urandom_range(1, 3)) cycle(0, r, mode);
    endtask

    // Called #1 after an edge: asserts reset mid-cycle, checks the async effect.
    task automatic async_reset(input int hold);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        repeat (hold) cycle(0, 4'($urandom), skip_idle);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) cycle(0, 4'hF, 1'b0);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_rotation();
        async_reset(1);
        ss_cnt = 0;
        for (int f = 0; f < 12; f++) begin
            tick_frame(1'b0, 4'($urandom));
            checks++;
            if (gid4 !== 2'(((f + 1) / 3) % 4)) begin
                errors++; $display("FAIL rotation frame %0d grant got %0d want %0d", f, gid4, ((f + 1) / 3) % 4);
            end
        end
        checks++;
        if (ss_cnt != 4) begin
            errors++; $display("FAIL rotation slot_start pulses got %0d want 4", ss_cnt);
        end
    endtask

    task automatic test_hold_match();
        async_reset(1);
        repeat (5) cycle(1, 4'h0, 1'b0);
        cycle(0, 4'h0, 1'b0);
        checks++;
        if (gid4 !== 2'd0) begin
            errors++; $display("FAIL hold_match grant after hold got %0d want 0", gid4);
        end
        tick_frame(1'b0, 4'h0);
        tick_frame(1'b0, 4'h0);
        checks++;
        if (gid4 !== 2'd1) begin
            errors++; $display("FAIL hold_match grant after 3 ticks got %0d want 1", gid4);
        end
    endtask

    task automatic test_early_release();
        async_reset(1);
        cycle(0, 4'b0100, 1'b1);
        cycle(1, 4'b0100, 1'b1);
        checks++;
        if (gid4 !== 2'd2 || ss4 !== 1'b1) begin
            errors++; $display("FAIL early_release grant/ss got %0d/%b want 2/1", gid4, ss4);
        end
        cycle(0, 4'b0100, 1'b1);
        checks++;
        if (ss4 !== 1'b0) begin
            errors++; $display("FAIL early_release ss second cycle got %b want 0", ss4);
        end
    endtask

    task automatic test_saturate();
        async_reset(1);
        repeat (5) tick_frame(1'b1, 4'b0000);
        checks++;
        if (gid4 !== 2'd0) begin
            errors++; $display("FAIL saturate idle grant got %0d want 0", gid4);
        end
        tick_frame(1'b1, 4'b0001);
        checks++;
        if (gid4 !== 2'd0) begin
            errors++; $display("FAIL saturate regrant got %0d want 0", gid4);
        end
        // A cleared counter needs three more ticks before client 1 gets in.
        tick_frame(1'b1, 4'b0011);
        tick_frame(1'b1, 4'b0011);
        checks++;
        if (gid4 !== 2'd0) begin
            errors++; $display("FAIL saturate counter not cleared grant got %0d want 0", gid4);
        end
        tick_frame(1'b1, 4'b0011);
        checks++;
        if (gid4 !== 2'd1) begin
            errors++; $display("FAIL saturate slot end grant got %0d want 1", gid4);
        end
    endtask

    task automatic test_three_clients();
        async_reset(1);
        seen_bad3 = 0;
        for (int f = 0; f < 12; f++) begin
            tick_frame(1'b0, 4'hF);
            checks++;
            if (gid3 !== 2'(((f + 1) / 3) % 3)) begin
                errors++; $display("FAIL three_clients frame %0d grant got %0d want %0d", f, gid3, ((f + 1) / 3) % 3);
            end
        end
        checks++;
        if (seen_bad3) begin
            errors++; $display("FAIL three_clients grant reached 3 got 1 want 0");
        end
    endtask

    task automatic test_reset_mid();
        async_reset(1);
        repeat (6) tick_frame(1'b0, 4'h0);
        cycle(1, 4'h0, 1'b0);
        checks++;
        if (gid4 !== 2'd2) begin
            errors++; $display("FAIL reset_mid setup grant got %0d want 2", gid4);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (ce4 !== 4'b0001 || gid4 !== 2'd0) begin
            errors++; $display("FAIL reset_mid async ce/grant got %b/%0d want 0001/0", ce4, gid4);
        end
        // Match held across release: first cycle out of reset must tick.
        cycle(1, 4'h0, 1'b0);
        #2;
        rst_n = 1'b1;
        cycle(1, 4'h0, 1'b0);
        cycle(0, 4'h0, 1'b0);
        tick_frame(1'b0, 4'h0);
        checks++;
        if (gid4 !== 2'd0) begin
            errors++; $display("FAIL reset_mid after 2 ticks got %0d want 0", gid4);
        end
        tick_frame(1'b0, 4'h0);
        checks++;
        if (gid4 !== 2'd1) begin
            errors++; $display("FAIL reset_mid after 3 ticks got %0d want 1", gid4);
        end
    endtask

    task automatic test_random();
        bit mode = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 40) == 0) mode = ~mode;
            if ($urandom_range(0, 250) == 0) async_reset($urandom_range(0, 2));
            cycle($urandom_range(0, 3) == 0, 4'($urandom), mode);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_hold_match();
        test_early_release();
        test_saturate();
        test_three_clients();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
